// File: rtl/axis_header_inserter_if.sv
// Bundles the payload, header and output AXI-Stream channels of axis_header_inserter.
// The slave modport is the inserter's view and the master modport is the environment's view.
interface axis_header_inserter_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
);
  logic                    valid_in;
  logic                    ready_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;

  logic                    valid_insert;
  logic                    ready_insert;
  logic [DATA_WD-1:0]      header_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;

  logic                    valid_out;
  logic                    ready_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;

  logic                    err;

  modport slave (
    input  valid_in, data_in, keep_in, last_in,
    input  valid_insert, header_insert, keep_insert,
    input  ready_out,
    output ready_in, ready_insert,
    output valid_out, data_out, keep_out, last_out, err
  );

  modport master (
    output valid_in, data_in, keep_in, last_in,
    output valid_insert, header_insert, keep_insert,
    output ready_out,
    input  ready_in, ready_insert,
    input  valid_out, data_out, keep_out, last_out, err
  );
endinterface

// File: rtl/axis_header_inserter.sv
// Prepends a 0..B byte header to each AXI-Stream packet and repacks the merged byte
// stream into full-width, left-aligned output beats behind a registered output stage.
module axis_header_inserter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input logic                   clk,
  input logic                   rst,
  axis_header_inserter_if.slave bus
);
  localparam int B  = DATA_BYTE_WD;
  localparam int CW = $clog2(B + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t             state;
  logic [DATA_WD-1:0] r;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      rem;
  logic [CW-1:0]      n_hdr;
  logic [CW-1:0]      m_in;
  logic [CW:0]        total;
  logic               out_free;
  logic               take_hdr;
  logic               take_in;
  logic [DATA_WD-1:0] r_left;
  logic [DATA_WD-1:0] merged;

  function automatic logic [CW-1:0] popcount(input logic [B-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < B; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [B-1:0] top_bits(input int unsigned k);
    return ~({B{1'b1}} >> k);
  endfunction

  function automatic logic [B-1:0] low_bits(input int unsigned k);
    return ~({B{1'b1}} << k);
  endfunction

  function automatic logic [DATA_WD-1:0] expand(input logic [B-1:0] k);
    logic [DATA_WD-1:0] e;
    for (int unsigned i = 0; i < B; i++) e[8*i +: 8] = {8{k[i]}};
    return e;
  endfunction

  assign out_free    = !bus.valid_out || bus.ready_out;
  assign bus.ready_in = (state == STREAM) && out_free;
  assign take_hdr    = bus.valid_insert && bus.ready_insert;
  assign take_in     = bus.valid_in && bus.ready_in;
  assign n_hdr       = popcount(bus.keep_insert);
  assign m_in        = popcount(bus.keep_in);
  assign total       = {1'b0, cnt} + {1'b0, m_in};

  // R is kept right-aligned; shifts by a full word width yield zero, covering cnt=0 and cnt=B.
  assign r_left = r << (8 * (B - int'(cnt)));
  assign merged = r_left | (bus.data_in >> (8 * int'(cnt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      r                <= '0;
      cnt              <= '0;
      rem              <= '0;
      bus.valid_out    <= 1'b0;
      bus.data_out     <= '0;
      bus.keep_out     <= '0;
      bus.last_out     <= 1'b0;
      bus.err          <= 1'b0;
      bus.ready_insert <= 1'b0;
    end else begin
      if (bus.valid_out && bus.ready_out) bus.valid_out <= 1'b0;

      case (state)
        IDLE: begin
          bus.ready_insert <= 1'b1;
          if (take_hdr) begin
            r                <= bus.header_insert & expand(low_bits(32'(n_hdr)));
            cnt              <= n_hdr;
            state            <= STREAM;
            bus.ready_insert <= 1'b0;
            if (bus.keep_insert != low_bits(32'(n_hdr))) bus.err <= 1'b1;
          end
        end

        STREAM: begin
          if (take_in) begin
            bus.valid_out <= 1'b1;
            if (!bus.last_in) begin
              bus.data_out <= merged;
              bus.keep_out <= '1;
              bus.last_out <= 1'b0;
              r            <= bus.data_in & expand(low_bits(32'(cnt)));
              if (bus.keep_in != '1) bus.err <= 1'b1;
            end else begin
              if (bus.keep_in == '0 || bus.keep_in != top_bits(32'(m_in))) bus.err <= 1'b1;
              if (int'(total) <= B) begin
                bus.data_out     <= merged & expand(top_bits(32'(total)));
                bus.keep_out     <= top_bits(32'(total));
                bus.last_out     <= 1'b1;
                state            <= IDLE;
                bus.ready_insert <= 1'b1;
              end else begin
                // Tail bytes overflow this beat: they sit at the top of R's cnt bytes.
                bus.data_out <= merged;
                bus.keep_out <= '1;
                bus.last_out <= 1'b0;
                r            <= bus.data_in & expand(low_bits(32'(cnt)));
                rem          <= CW'(int'(total) - B);
                state        <= FLUSH;
              end
            end
          end
        end

        FLUSH: begin
          if (out_free) begin
            bus.valid_out    <= 1'b1;
            bus.data_out     <= r_left & expand(top_bits(32'(rem)));
            bus.keep_out     <= top_bits(32'(rem));
            bus.last_out     <= 1'b1;
            state            <= IDLE;
            bus.ready_insert <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_header_inserter.sv
// Bench for axis_header_inserter (DATA_WD=32): directed vector table, random packets
// against a byte-stream reference model, and error / mid-packet reset sequences.
module tb_axis_header_inserter;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [31:0]      hdr;
    logic [3:0]       kins;
    logic [1:0]       np;
    logic [1:0][31:0] pay;
    logic [3:0]       lk;
    logic [1:0]       ne;
    logic [2:0][31:0] ed;
    logic [2:0][3:0]  ek;
    logic [2:0]       el;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ro_mode = 1;
  beat_t got_q[$];
  beat_t exp_q[$];

  axis_header_inserter_if #(.DATA_WD(32)) bus();

  axis_header_inserter #(.DATA_WD(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on the DUT", name);
  endtask

  // ready_out: 0 = held low, 1 = held high, otherwise random 50%
  initial begin
    bus.ready_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ro_mode)
        0:       bus.ready_out = 1'b0;
        1:       bus.ready_out = 1'b1;
        default: bus.ready_out = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output collector and stall-stability monitor
  initial begin
    bit    stalled;
    beat_t held;
    beat_t cur;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        cur = '{d: bus.data_out, k: bus.keep_out, l: bus.last_out};
        if (stalled) check("stall_hold", {27'd0, bus.valid_out, 32'(cur)}, {27'd0, 1'b1, 32'(held)});
        if (bus.valid_out && bus.ready_out) got_q.push_back(cur);
        stalled = bus.valid_out && !bus.ready_out;
        held = cur;
      end
    end
  end

  // Reference: header bytes then payload bytes, chunked into left-aligned 4-byte beats.
  function automatic void model(input logic [31:0] hdr, input logic [3:0] kins,
                                input logic [31:0] pd[$], input logic [3:0] lk);
    logic [7:0] by[$];
    int n;
    n = $countones(kins);
    for (int j = n - 1; j >= 0; j--) by.push_back(hdr[8*j +: 8]);
    foreach (pd[i]) begin
      int m;
      m = (i == pd.size() - 1) ? $countones(lk) : 4;
      for (int j = 0; j < m; j++) by.push_back(pd[i][31-8*j -: 8]);
    end
    while (by.size() > 0) begin
      beat_t b;
      b = '0;
      for (int j = 0; j < 4 && by.size() > 0; j++) begin
        b.d[31-8*j -: 8] = by.pop_front();
        b.k[3-j] = 1'b1;
      end
      b.l = (by.size() == 0);
      exp_q.push_back(b);
    end
  endfunction

  task automatic do_header(input logic [31:0] hdr, input logic [3:0] kins);
    bit hs;
    int unsigned g;
    bus.header_insert = hdr;
    bus.keep_insert = kins;
    bus.valid_insert = 1'b1;
    hs = 0;
    g = 0;
    while (!hs && g < 1000) begin
      @(negedge clk);
      hs = bus.ready_insert;
      @(posedge clk);
      #1;
      g++;
    end
    if (!hs) fail_timeout("header_handshake");
    bus.valid_insert = 1'b0;
  endtask

  task automatic do_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit hs;
    int unsigned g;
    bus.valid_in = 1'b1;
    bus.data_in = d;
    bus.keep_in = k;
    bus.last_in = l;
    hs = 0;
    g = 0;
    while (!hs && g < 1000) begin
      @(negedge clk);
      hs = bus.ready_in;
      @(posedge clk);
      #1;
      g++;
    end
    if (!hs) fail_timeout("payload_handshake");
    bus.valid_in = 1'b0;
  endtask

  task automatic send_packet(input logic [31:0] hdr, input logic [3:0] kins,
                             input logic [31:0] pd[$], input logic [3:0] lk,
                             input bit early, input bit gaps);
    if (early) begin
      bus.valid_in = 1'b1;
      bus.data_in = pd[0];
      bus.keep_in = (pd.size() == 1) ? lk : 4'hF;
      bus.last_in = (pd.size() == 1);
    end
    do_header(hdr, kins);
    foreach (pd[i]) begin
      if (gaps && !(early && i == 0) && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      do_beat(pd[i], (i == pd.size() - 1) ? lk : 4'hF, i == pd.size() - 1);
    end
  endtask

  task automatic wait_beats(input int n, input string name);
    int unsigned g;
    g = 0;
    while (got_q.size() < n && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (got_q.size() < n) fail_timeout(name);
  endtask

  initial begin
    vec_t        vecs[5];
    logic [31:0] pd[$];
    beat_t       g;
    beat_t       e;
    int          nlast;

    vecs[0] = '{hdr: 32'hAABBCCDD, kins: 4'b0111, np: 2, pay: {32'h55667788, 32'h11223344},
                lk: 4'b1100, ne: 3, ed: {32'h66000000, 32'h22334455, 32'hBBCCDD11},
                ek: {4'b1000, 4'b1111, 4'b1111}, el: 3'b100};
    vecs[1] = '{hdr: 32'hCAFEF00D, kins: 4'b1111, np: 1, pay: {32'h0, 32'h01020304},
                lk: 4'b1000, ne: 2, ed: {32'h0, 32'h01000000, 32'hCAFEF00D},
                ek: {4'b0000, 4'b1000, 4'b1111}, el: 3'b010};
    vecs[2] = '{hdr: 32'h12345678, kins: 4'b0000, np: 1, pay: {32'h0, 32'h01020304},
                lk: 4'b1110, ne: 1, ed: {32'h0, 32'h0, 32'h01020300},
                ek: {4'b0000, 4'b0000, 4'b1110}, el: 3'b001};
    vecs[3] = '{hdr: 32'h00000099, kins: 4'b0001, np: 1, pay: {32'h0, 32'hA1A2A3A4},
                lk: 4'b1110, ne: 1, ed: {32'h0, 32'h0, 32'h99A1A2A3},
                ek: {4'b0000, 4'b0000, 4'b1111}, el: 3'b001};
    vecs[4] = '{hdr: 32'h0000BEEF, kins: 4'b0011, np: 2, pay: {32'h50607080, 32'h10203040},
                lk: 4'b1000, ne: 2, ed: {32'h0, 32'h30405000, 32'hBEEF1020},
                ek: {4'b0000, 4'b1110, 4'b1111}, el: 3'b010};

    bus.valid_in = 0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 0;
    bus.valid_insert = 0; bus.header_insert = '0; bus.keep_insert = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({bus.valid_out, bus.data_out, bus.keep_out, bus.last_out, bus.err, bus.ready_in, bus.ready_insert}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_insert_after_reset", 64'(bus.ready_insert), 64'd1);

    // Directed vector table
    ro_mode = 1;
    foreach (vecs[i]) begin
      pd.delete();
      for (int j = 0; j < int'(vecs[i].np); j++) pd.push_back(vecs[i].pay[j]);
      send_packet(vecs[i].hdr, vecs[i].kins, pd, vecs[i].lk, 1'b0, 1'b0);
      wait_beats(int'(vecs[i].ne), $sformatf("vec%0d_beats", i));
      for (int j = 0; j < int'(vecs[i].ne) && got_q.size() > 0; j++) begin
        g = got_q.pop_front();
        e = '{d: vecs[i].ed[j], k: vecs[i].ek[j], l: vecs[i].el[j]};
        check($sformatf("vec%0d_beat%0d", i, j), 64'(g), 64'(e));
      end
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("vec%0d_extra_beats", i), 64'(got_q.size()), 64'd0);
      got_q.delete();
    end
    check("err_after_vectors", 64'(bus.err), 64'd0);

    // Random packets under random backpressure
    ro_mode = 2;
    exp_q.delete();
    got_q.delete();
    for (int p = 0; p < 200; p++) begin
      int n;
      int len;
      int m;
      logic [31:0] hdr;
      logic [3:0]  kins;
      logic [3:0]  lk;
      n = $urandom_range(0, 4);
      len = $urandom_range(1, 5);
      m = $urandom_range(1, 4);
      hdr = $urandom;
      kins = 4'((1 << n) - 1);
      lk = 4'(4'hF << (4 - m));
      pd.delete();
      for (int j = 0; j < len; j++) pd.push_back($urandom);
      model(hdr, kins, pd, lk);
      send_packet(hdr, kins, pd, lk, 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_beats(exp_q.size(), "random_beats");
    ro_mode = 1;
    nlast = 0;
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        if (got_q[i].l) nlast++;
        check($sformatf("rand_beat%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
      end
    end
    check("rand_beat_count", 64'(got_q.size()), 64'(exp_q.size()));
    check("rand_last_count", 64'(nlast), 64'd200);
    check("err_after_random", 64'(bus.err), 64'd0);
    got_q.delete();
    exp_q.delete();

    // Malformed keep on a non-last beat sets the sticky error
    do_header(32'h0, 4'b0000);
    do_beat(32'h11111111, 4'b1110, 1'b0);
    check("err_set", 64'(bus.err), 64'd1);
    do_beat(32'h22222222, 4'b1111, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", 64'(bus.err), 64'd1);

    // Reset mid-packet while the output register is stalled
    ro_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    do_header(32'h01020304, 4'b0011);
    do_beat(32'hDEADBEEF, 4'hF, 1'b0);
    check("stalled_valid_out", 64'(bus.valid_out), 64'd1);
    bus.valid_in = 1'b1;
    bus.data_in = 32'h01234567;
    bus.keep_in = 4'hF;
    bus.last_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("midpkt_reset_outputs",
          64'({bus.valid_out, bus.data_out, bus.keep_out, bus.last_out, bus.err, bus.ready_in, bus.ready_insert}), 64'd0);
    rst = 1'b0;
    ro_mode = 1;
    @(posedge clk);
    #1;
    check("midpkt_ready_insert", 64'(bus.ready_insert), 64'd1);
    got_q.delete();
    exp_q.delete();
    pd.delete();
    pd.push_back(32'hA0B0C0D0);
    pd.push_back(32'hE0F01020);
    model(32'h00777777, 4'b0111, pd, 4'b1110);
    send_packet(32'h00777777, 4'b0111, pd, 4'b1110, 1'b0, 1'b0);
    wait_beats(exp_q.size(), "post_reset_beats");
    foreach (exp_q[i]) begin
      if (i < got_q.size()) check($sformatf("post_reset_beat%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    check("post_reset_beat_count", 64'(got_q.size()), 64'(exp_q.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
